rr_resource_arbiter: RTL and testbench

//   Round-robin arbiter sharing one downstream resource among WIDTH requesters.

---
 rtl/rr_resource_arbiter_pkg.sv | 19 +
 rtl/rr_resource_arbiter_mask_select.sv | 40 ++++
 rtl/rr_resource_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_resource_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_resource_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin resource arbiter.
package rr_resource_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_BUSY  = 2'd2
   } arb_state_e;

   localparam int DEF_WIDTH = 4;

   // $clog2 that never returns 0, so a 1-entry range still gets a real bit.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

   localparam int IDX_W = clog2_min1(DEF_WIDTH);

endpackage

// File: rtl/rr_resource_arbiter_mask_select.sv
// Combinational round-robin pick: first set request at or after ptr, as one-hot and index.
module rr_mask_select
   import rr_resource_arbiter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int PTR_W   = clog2_min1(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [WIDTH-1:0] win_onehot,
   output logic [PTR_W-1:0] win_idx
);

   logic [2*WIDTH-1:0] rot_dbl;
   logic [2*WIDTH-1:0] back_dbl;
   logic [WIDTH-1:0]   rot;
   logic [WIDTH-1:0]   pick;
   logic [PTR_W-1:0]   pos;

   // Doubling the vector makes the rotation correct for non-power-of-two widths.
   always_comb begin
      rot_dbl    = {req, req} >> ptr;
      rot        = rot_dbl[WIDTH-1:0];
      pick       = rot & (~rot + {{(WIDTH-1){1'b0}}, 1'b1});
      back_dbl   = {pick, pick} << ptr;
      win_onehot = back_dbl[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      win_idx = '0;
      pos     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pos = PTR_W'(i);
         for (int b = 0; b < PTR_W; b++) begin
            if (pos[b]) win_idx[b] = win_idx[b] | win_onehot[i];
         end
      end
   end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared resource: offer, accept/done hold, timeout release.
module rr_resource_arbiter
   import rr_resource_arbiter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 64
) (
   input  logic                         iClk,
   input  logic                         iRst,
   input  logic [WIDTH-1:0]             iReq,
   input  logic                         iAccept,
   input  logic                         iDone,
   output logic [WIDTH-1:0]             oGnt,
   output logic [clog2_min1(WIDTH)-1:0] oGntIdx,
   output logic                         oGntValid,
   output logic                         oBusy,
   output logic                         oTimeout
);

   localparam int PTR_W = clog2_min1(WIDTH);
   localparam int CNT_W = clog2_min1(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WIDTH - 1);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] gnt_q, gnt_d;
   logic [PTR_W-1:0] gnt_idx_q, gnt_idx_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   logic [WIDTH-1:0] win_onehot;
   logic [PTR_W-1:0] win_idx;
   logic             release_now;

   rr_mask_select #(
      .WIDTH (WIDTH),
      .PTR_W (PTR_W)
   ) u_mask_select (
      .req        (iReq),
      .ptr        (ptr_q),
      .win_onehot (win_onehot),
      .win_idx    (win_idx)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      release_now = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (|iReq) begin
               gnt_d       = win_onehot;
               gnt_idx_d   = win_idx;
               gnt_valid_d = 1'b1;
               state_d     = ST_OFFER;
            end
         end
         ST_OFFER: begin
            // Accept takes precedence over a same-cycle withdrawal.
            if (iAccept) begin
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end else if (!iReq[gnt_idx_q]) begin
               gnt_d       = '0;
               gnt_idx_d   = '0;
               gnt_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            if (iDone) begin
               release_now = 1'b1;
            end else if ((MAX_HOLD != 0) && (cnt_q == HOLD_LAST)) begin
               release_now = 1'b1;
               timeout_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (release_now) begin
         ptr_d       = (gnt_idx_q == PTR_LAST) ? '0 : gnt_idx_q + PTR_W'(1);
         gnt_d       = '0;
         gnt_idx_d   = '0;
         gnt_valid_d = 1'b0;
         busy_d      = 1'b0;
         state_d     = ST_IDLE;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   assign oGnt      = gnt_q;
   assign oGntIdx   = gnt_idx_q;
   assign oGntValid = gnt_valid_q;
   assign oBusy     = busy_q;
   assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter (WIDTH=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_resource_arbiter;

   logic       iClk = 1'b0;
   logic       iRst;
   logic [3:0] iReq;
   logic       iAccept;
   logic       iDone;
   logic [3:0] oGnt;
   logic [1:0] oGntIdx;
   logic       oGntValid;
   logic       oBusy;
   logic       oTimeout;

   int vectors = 0;
   int miscompares = 0;

   rr_resource_arbiter #(
      .WIDTH    (4),
      .MAX_HOLD (8)
   ) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iReq      (iReq),
      .iAccept   (iAccept),
      .iDone     (iDone),
      .oGnt      (oGnt),
      .oGntIdx   (oGntIdx),
      .oGntValid (oGntValid),
      .oBusy     (oBusy),
      .oTimeout  (oTimeout)
   );

   always #5 iClk = ~iClk;

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   // Packed compare of {gnt, idx, valid, busy, timeout}.
   task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] idx,
                      input logic v, input logic b, input logic t);
      logic [8:0] obs;
      logic [8:0] exp;
      obs = {oGnt, oGntIdx, oGntValid, oBusy, oTimeout};
      exp = {g, idx, v, b, t};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed gnt/idx/v/b/t=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_ptr(input string tag, input logic [1:0] exp);
      vectors++;
      assert (dut.ptr_q === exp) else begin
         miscompares++;
         $error("FAIL %s: observed ptr=%0d expected %0d", tag, dut.ptr_q, exp);
      end
   endtask

   initial begin
      logic [1:0] exp_idx;
      iRst = 1'b1; iReq = 4'b0000; iAccept = 1'b0; iDone = 1'b0;
      step();
      chk("reset", 4'b0000, 2'd0, 0, 0, 0);
      chk_ptr("reset_ptr", 2'd0);
      iRst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_no_req", 4'b0000, 2'd0, 0, 0, 0);
      end

      // Accept while idle must be ignored
      iAccept = 1'b1;
      step();
      chk("idle_accept_ignored", 4'b0000, 2'd0, 0, 0, 0);
      iAccept = 1'b0;

      // 1010 from ptr 0 -> req 1, then ptr 2 -> req 3
      iReq = 4'b1010;
      step();
      chk("offer_1", 4'b0010, 2'd1, 1, 0, 0);
      iAccept = 1'b1;
      step();
      chk("busy_1", 4'b0010, 2'd1, 1, 1, 0);
      iAccept = 1'b0; iDone = 1'b1;
      step();
      chk("release_1", 4'b0000, 2'd0, 0, 0, 0);
      chk_ptr("ptr_after_1", 2'd2);
      iDone = 1'b0;
      step();
      chk("offer_3", 4'b1000, 2'd3, 1, 0, 0);
      iAccept = 1'b1;
      step();
      chk("busy_3", 4'b1000, 2'd3, 1, 1, 0);
      iAccept = 1'b0; iDone = 1'b1;
      step();
      chk("release_3", 4'b0000, 2'd0, 0, 0, 0);
      chk_ptr("ptr_wrap", 2'd0);
      iDone = 1'b0;

      // All requesting: order 0,1,2,3,0 with an idle gap between grants
      iReq = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_idx = 2'(k % 4);
         step();
         chk("rr_offer", 4'b0001 << exp_idx, exp_idx, 1, 0, 0);
         iAccept = 1'b1;
         step();
         chk("rr_busy", 4'b0001 << exp_idx, exp_idx, 1, 1, 0);
         iAccept = 1'b0; iDone = 1'b1;
         step();
         chk("rr_gap", 4'b0000, 2'd0, 0, 0, 0);
         iDone = 1'b0;
      end
      chk_ptr("rr_ptr", 2'd1);

      // Bring ptr back to 0 via a grant to req 3
      iReq = 4'b1000;
      step();
      chk("offer_3b", 4'b1000, 2'd3, 1, 0, 0);
      iAccept = 1'b1;
      step();
      iAccept = 1'b0; iDone = 1'b1;
      step();
      iDone = 1'b0;
      chk_ptr("ptr_back_0", 2'd0);

      // Withdrawal during offer; iDone in OFFER is ignored
      iReq = 4'b0100;
      step();
      chk("offer_2", 4'b0100, 2'd2, 1, 0, 0);
      iDone = 1'b1;
      step();
      chk("offer_done_ignored", 4'b0100, 2'd2, 1, 0, 0);
      iDone = 1'b0; iReq = 4'b0000;
      step();
      chk("withdraw", 4'b0000, 2'd0, 0, 0, 0);
      chk_ptr("withdraw_ptr", 2'd0);
      iReq = 4'b0100;
      step();
      chk("reoffer_2", 4'b0100, 2'd2, 1, 0, 0);

      // Timeout after 8 BUSY cycles without iDone
      iAccept = 1'b1;
      step();
      chk("to_busy_c1", 4'b0100, 2'd2, 1, 1, 0);
      iAccept = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         step();
         chk("to_busy_hold", 4'b0100, 2'd2, 1, 1, 0);
      end
      step();
      chk("timeout_pulse", 4'b0000, 2'd0, 0, 0, 1);
      chk_ptr("timeout_ptr", 2'd3);
      step();
      chk("timeout_one_cycle", 4'b0100, 2'd2, 1, 0, 0);

      // iDone on the 8th BUSY cycle: normal release, no timeout
      iAccept = 1'b1;
      step();
      chk("dn_busy_c1", 4'b0100, 2'd2, 1, 1, 0);
      iAccept = 1'b0;
      for (int c = 2; c <= 8; c++) begin
         step();
         chk("dn_busy_hold", 4'b0100, 2'd2, 1, 1, 0);
      end
      iDone = 1'b1;
      step();
      chk("done_at_limit", 4'b0000, 2'd0, 0, 0, 0);
      chk_ptr("done_at_limit_ptr", 2'd3);
      iDone = 1'b0;

      // ptr 3 scans 3,0,1: req 1 wins; accept beats same-cycle withdrawal
      iReq = 4'b0010;
      step();
      chk("offer_1b", 4'b0010, 2'd1, 1, 0, 0);
      iReq = 4'b0000; iAccept = 1'b1;
      step();
      chk("accept_wins", 4'b0010, 2'd1, 1, 1, 0);
      iAccept = 1'b0;
      step();
      chk("busy_no_req", 4'b0010, 2'd1, 1, 1, 0);

      // Reset during BUSY drops everything
      iRst = 1'b1;
      step();
      chk("reset_busy", 4'b0000, 2'd0, 0, 0, 0);
      chk_ptr("reset_busy_ptr", 2'd0);
      iRst = 1'b0; iReq = 4'b1000;
      step();
      chk("post_reset_offer", 4'b1000, 2'd3, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
